ps2_keystroke_decoder: RTL

PS2_KEYSTROKE_DECODER -- requirements
Module: ps2_keystroke_decoder

---
 rtl/ps2_keystroke_decoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ps2_keystroke_decoder.sv
// PS/2 set-2 keystroke decoder: parses make/break byte streams, tracks the held
// letter key and queues uppercase-ASCII keystrokes for a downstream consumer.
module ps2_keystroke_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_ascii,
  output logic [7:0] o_scan,
  output logic       o_rotate,
  output logic       o_key_held,
  output logic       o_overflow
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CODE_EXT = 8'hE0;
  localparam logic [BYTE_W-1:0] CODE_BRK = 8'hF0;

  typedef struct packed {
    logic [BYTE_W-1:0] ascii;
    logic [BYTE_W-1:0] scan;
  } key_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  // Set-2 make code to uppercase ASCII; 0x00 means "not a letter".
  function automatic logic [BYTE_W-1:0] scan_to_ascii(input logic [BYTE_W-1:0] code);
    logic [BYTE_W-1:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
      8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
      8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
      8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
      8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
      8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] held_q, held_d;
  logic              key_held_q, key_held_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              rotate_q, rotate_d;
  logic              overflow_q, overflow_d;
  key_entry_t        mem_q [FIFO_DEPTH];
  key_entry_t        mem_d [FIFO_DEPTH];

  logic [BYTE_W-1:0] ascii_c;
  logic              enq_req_c;
  logic              deq_c;
  logic              full_c;
  logic              push_c;
  key_entry_t        head_c;

  // Byte parser and held-key tracking.
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    key_held_d = key_held_q;
    enq_req_c  = 1'b0;
    ascii_c    = scan_to_ascii(received_data);

    if (received_data_en) begin
      case (state_q)
        IDLE: begin
          if (received_data == CODE_EXT) begin
            state_d = EXT;
          end else if (received_data == CODE_BRK) begin
            state_d = BRK;
          end else if ((ascii_c != 8'h00) && (received_data != held_q)) begin
            held_d     = received_data;
            key_held_d = 1'b1;
            enq_req_c  = 1'b1;
          end
        end
        EXT: begin
          state_d = (received_data == CODE_BRK) ? EXT_BRK : IDLE;
        end
        BRK: begin
          state_d = IDLE;
          if (key_held_q && (received_data == held_q)) begin
            held_d     = 8'h00;
            key_held_d = 1'b0;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Keystroke FIFO; a full queue still accepts when the head leaves this cycle.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    full_c = (count_q == CNT_W'(FIFO_DEPTH));
    deq_c  = valid_q && i_ready;
    push_c = enq_req_c && (!full_c || deq_c);

    if (push_c) begin
      mem_d[wr_ptr_q] = '{ascii: ascii_c, scan: received_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (deq_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (enq_req_c && full_c && !deq_c) begin
      overflow_d = 1'b1;
    end

    count_d  = count_q + CNT_W'(push_c) - CNT_W'(deq_c);
    valid_d  = (count_d != '0);
    rotate_d = deq_c;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      held_q     <= 8'h00;
      key_held_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      rotate_q   <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      key_held_q <= key_held_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      rotate_q   <= rotate_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign head_c     = mem_q[rd_ptr_q];
  assign o_valid    = valid_q;
  assign o_ascii    = valid_q ? head_c.ascii : 8'h00;
  assign o_scan     = valid_q ? head_c.scan  : 8'h00;
  assign o_rotate   = rotate_q;
  assign o_key_held = key_held_q;
  assign o_overflow = overflow_q;

endmodule
